// File: rtl/pipeline_spi_command_master_pkg.sv
// pipeline_spi_command_master_pkg: opcodes, argument-count lookup and SPI mode shared by master and slave decoder
package pipeline_spi_command_master_pkg;
  localparam logic [7:0] CMD_NOP      = 8'h00;
  localparam logic [7:0] CMD_ENABLE   = 8'h01;
  localparam logic [7:0] CMD_MODE     = 8'h02;
  localparam logic [7:0] CMD_ALPHA    = 8'h03;
  localparam logic [7:0] CMD_OFFSET_X = 8'h04;
  localparam logic [7:0] CMD_OFFSET_Y = 8'h05;
  localparam logic [7:0] CMD_LAYER    = 8'h06;
  localparam logic [7:0] CMD_WIDTH    = 8'h07;
  localparam logic [7:0] CMD_HEIGHT   = 8'h08;
  localparam logic [7:0] CMD_KEY_LO   = 8'h09;
  localparam logic [7:0] CMD_KEY_HI   = 8'h0A;
  localparam logic [7:0] CMD_STATUS   = 8'h0B;
  localparam logic [7:0] CMD_IMAGE    = 8'h0C;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [1:0] ARGS_NONE    = 2'd0;
  localparam logic [1:0] ARGS_ONE     = 2'd1;
  localparam logic [1:0] ARGS_TWO     = 2'd2;
  localparam logic [1:0] ARGS_STREAM  = 2'd3;
  localparam logic       SPI_CPOL     = 1'b0;
  localparam logic       SPI_CPHA     = 1'b0;
  function automatic logic [1:0] arg_count(input logic [7:0] op);
    case (op)
      CMD_ENABLE, CMD_MODE, CMD_ALPHA, CMD_LAYER, CMD_STATUS: return ARGS_ONE;
      CMD_OFFSET_X, CMD_OFFSET_Y, CMD_WIDTH, CMD_HEIGHT, CMD_KEY_LO, CMD_KEY_HI: return ARGS_TWO;
      CMD_IMAGE: return ARGS_STREAM;
      default: return ARGS_NONE;
    endcase
  endfunction
endpackage

// File: rtl/pipeline_spi_command_master_byte_shifter.sv
// spi_master_byte_shifter: mode-0 byte engine owning sclk, mosi, clock divider and bit counter
module spi_master_byte_shifter #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] byte_in,
  input  logic       miso,
  output logic       done,
  output logic [7:0] byte_out,
  output logic       sclk,
  output logic       mosi
);
  localparam int DVW = $clog2(CLK_DIV);
  logic           run, upd, edge_now;
  logic [DVW-1:0] div;
  logic [2:0]     bit_cnt;
  logic [7:0]     tx, rx;
  // done fires on the cycle of the last falling edge so the next byte can load on that same edge
  always_comb begin
    edge_now = run && div == DVW'(CLK_DIV - 1);
    done = edge_now && sclk && bit_cnt == 3'd7;
  end
  // divider, sclk toggling, MSB-first shift out and MISO capture on rising edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run <= 1'b0;
      upd <= 1'b0;
      div <= '0;
      bit_cnt <= 3'd0;
      tx <= 8'd0;
      rx <= 8'd0;
      byte_out <= 8'd0;
      sclk <= 1'b0;
      mosi <= 1'b0;
    end else begin
      upd <= 1'b0;
      if (upd) byte_out <= rx;
      if (start) begin
        run <= 1'b1;
        div <= '0;
        bit_cnt <= 3'd0;
        tx <= byte_in;
        sclk <= 1'b0;
        mosi <= byte_in[7];
      end else if (run) begin
        div <= edge_now ? '0 : div + 1'b1;
        if (edge_now) begin
          sclk <= ~sclk;
          if (!sclk) begin
            rx <= {rx[6:0], miso};
            upd <= bit_cnt == 3'd7;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            tx <= tx << 1;
            mosi <= tx[6];
            if (bit_cnt == 3'd7) run <= 1'b0;
          end
        end
      end
    end
  end
endmodule

// File: rtl/pipeline_spi_command_master.sv
// pipeline_spi_command_master: frames overlay commands (opcode, args or pixel stream) onto SPI
module pipeline_spi_command_master
  import pipeline_spi_command_master_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int SS_SETUP   = 2,
  parameter int SS_GAP     = 4,
  parameter int PIXEL_SIZE = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [7:0]            cmd_opcode,
  input  logic [15:0]           cmd_arg,
  input  logic                  px_valid,
  output logic                  px_ready,
  input  logic [PIXEL_SIZE-1:0] px_data,
  input  logic                  px_last,
  output logic                  busy,
  output logic [7:0]            miso_byte,
  output logic                  hw_spi_clk,
  output logic                  hw_spi_ss,
  output logic                  hw_spi_mosi,
  input  logic                  hw_spi_miso
);
  localparam int PB = PIXEL_SIZE / 8;
  localparam int DW = PIXEL_SIZE > 16 ? PIXEL_SIZE : 16;
  localparam int BW = $clog2((PB > 2 ? PB : 2) + 1);
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, STREAM_WAIT, GAP} state_t;
  state_t        state;
  logic [7:0]    op, cnt, byte_in;
  logic [DW-1:0] data;
  logic [BW-1:0] pend;
  logic          last, done, start, stream, px_go;
  spi_master_byte_shifter #(.CLK_DIV(CLK_DIV)) u_shifter (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_in(byte_in), .miso(hw_spi_miso),
    .done(done), .byte_out(miso_byte), .sclk(hw_spi_clk), .mosi(hw_spi_mosi)
  );
  // byte launch: opcode after setup, queued bytes back-to-back, a pixel's first byte on accept
  always_comb begin
    stream = arg_count(op) == ARGS_STREAM;
    px_go = state == STREAM_WAIT && px_valid;
    start = (state == SETUP && cnt == 8'(SS_SETUP - 1)) || (state == SHIFT && done && pend != '0) || px_go;
    byte_in = state == SETUP ? op : px_go ? px_data[PIXEL_SIZE-1 -: 8] : data[DW-1 -: 8];
  end
  // frame sequencing with registered handshake and slave-select outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      hw_spi_ss <= 1'b1;
      cmd_ready <= 1'b1;
      px_ready <= 1'b0;
      busy <= 1'b0;
      op <= 8'd0;
      cnt <= 8'd0;
      data <= '0;
      pend <= '0;
      last <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          op <= cmd_opcode;
          data <= arg_count(cmd_opcode) == ARGS_TWO ? DW'(cmd_arg) << (DW - 16) : DW'(cmd_arg[7:0]) << (DW - 8);
          pend <= BW'(arg_count(cmd_opcode) == ARGS_STREAM ? ARGS_NONE : arg_count(cmd_opcode));
          last <= 1'b0;
          cnt <= 8'd0;
          hw_spi_ss <= 1'b0;
          cmd_ready <= 1'b0;
          busy <= 1'b1;
          state <= SETUP;
        end
        SETUP: begin
          cnt <= cnt + 1'b1;
          if (start) state <= SHIFT;
        end
        SHIFT: if (done) begin
          if (pend != '0) begin
            data <= data << 8;
            pend <= pend - 1'b1;
          end else if (stream && !last) begin
            px_ready <= 1'b1;
            state <= STREAM_WAIT;
          end else begin
            hw_spi_ss <= 1'b1;
            cnt <= 8'd0;
            state <= GAP;
          end
        end
        STREAM_WAIT: if (px_valid) begin
          data <= DW'(px_data) << (DW - PIXEL_SIZE + 8);
          pend <= BW'(PB - 1);
          last <= px_last;
          px_ready <= 1'b0;
          state <= SHIFT;
        end
        GAP: begin
          cnt <= cnt + 1'b1;
          if (cnt == 8'(SS_GAP - 1)) begin
            cmd_ready <= 1'b1;
            busy <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pipeline_spi_command_master.sv
// tb_pipeline_spi_command_master: randomized scoreboard bench with an SPI slave monitor
module tb_pipeline_spi_command_master;
  localparam int CLK_DIV = 4, SS_SETUP = 2, SS_GAP = 4, PIXEL_SIZE = 16;
  localparam int PB = PIXEL_SIZE / 8;
  logic clk = 1'b0, rst_n = 1'b1, cmd_valid = 1'b0, px_valid = 1'b0, px_last = 1'b0, hw_spi_miso = 1'b0;
  logic cmd_ready, px_ready, busy, hw_spi_clk, hw_spi_ss, hw_spi_mosi;
  logic [7:0] cmd_opcode = 8'd0, miso_byte;
  logic [15:0] cmd_arg = 16'd0;
  logic [PIXEL_SIZE-1:0] px_data = '0;
  int n_cmp = 0, n_fail = 0;
  byte unsigned exp_bytes[$];
  int exp_len[$];
  logic [PIXEL_SIZE-1:0] px_q[$];
  bit fix_miso = 1'b0;

  pipeline_spi_command_master #(.CLK_DIV(CLK_DIV), .SS_SETUP(SS_SETUP), .SS_GAP(SS_GAP), .PIXEL_SIZE(PIXEL_SIZE)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_arg(cmd_arg), .px_valid(px_valid), .px_ready(px_ready), .px_data(px_data), .px_last(px_last),
    .busy(busy), .miso_byte(miso_byte), .hw_spi_clk(hw_spi_clk), .hw_spi_ss(hw_spi_ss),
    .hw_spi_mosi(hw_spi_mosi), .hw_spi_miso(hw_spi_miso)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int n_args(input logic [7:0] op);
    if (op == 8'h0C) return 3;
    if (op inside {8'h01, 8'h02, 8'h03, 8'h06, 8'h0B}) return 1;
    if (op inside {[8'h04:8'h05], [8'h07:8'h0A]}) return 2;
    return 0;
  endfunction

  function automatic byte unsigned pick();
    return fix_miso ? 8'hA5 : 8'($urandom);
  endfunction

  // slave-side monitor: decodes frames, drives MISO, checks bytes, timing and gap
  logic p_ss = 1'b1, p_sclk = 1'b0, p_mosi = 1'b0;
  bit in_frame = 0, gap_on = 0, mpend = 0;
  int run = 0, len = 0, fcyc = 0, gap = 0, rb = 0, nb = 0, hi_bad = 0, lo_bad = 0;
  byte unsigned sh = 0, tx = 0, mexp = 0, first = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      in_frame = 0; gap_on = 0; mpend = 0; rb = 0;
      p_ss = 1'b1; p_sclk = 1'b0; p_mosi = 1'b0; hw_spi_miso = 1'b0;
    end else begin
      if (mpend) begin chk("miso_byte", miso_byte, mexp); mpend = 0; end
      if (gap_on) begin
        gap++;
        if (cmd_ready) begin chk("ss_gap_cycles", gap, SS_GAP); gap_on = 0; end
      end
      if (hw_spi_clk != p_sclk) begin len = run; run = 1; end else run++;
      if (p_ss && !hw_spi_ss) begin
        in_frame = 1; fcyc = 0; rb = 0; nb = 0; hi_bad = 0; lo_bad = 0;
        tx = pick(); hw_spi_miso = tx[7];
      end else if (in_frame) begin
        fcyc++;
        if (hw_spi_clk && !p_sclk) begin
          if (nb == 0 && rb == 0) begin if (fcyc != SS_SETUP + CLK_DIV) lo_bad++; end
          else if (first == 8'h0C && rb == 0) begin if (len < CLK_DIV) lo_bad++; end
          else if (len != CLK_DIV) lo_bad++;
          sh = {sh[6:0], hw_spi_mosi};
          rb++;
          if (rb == 8) begin
            rb = 0;
            if (nb == 0) first = sh;
            nb++;
            if (exp_bytes.size() == 0) chk("frame_byte_unexpected", sh, 256);
            else chk("frame_byte", sh, exp_bytes.pop_front());
            mexp = tx; mpend = 1;
          end
        end else if (!hw_spi_clk && p_sclk) begin
          if (len != CLK_DIV) hi_bad++;
          if (rb == 0) begin tx = pick(); hw_spi_miso = tx[7]; end
          else hw_spi_miso = tx[7-rb];
        end else if (hw_spi_clk && hw_spi_mosi != p_mosi) hi_bad++;
      end
      if (!p_ss && hw_spi_ss && in_frame) begin
        if (exp_len.size() == 0) chk("frame_len_unexpected", nb, -1);
        else chk("frame_len", nb, exp_len.pop_front());
        chk("frame_sclk_high_phase", hi_bad, 0);
        chk("frame_sclk_low_phase", lo_bad, 0);
        in_frame = 0; gap_on = 1; gap = 0;
      end
      p_ss = hw_spi_ss; p_sclk = hw_spi_clk; p_mosi = hw_spi_mosi;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 5000) begin @(negedge clk); n++; end
    if (!cmd_ready) chk("cmd_ready_timeout", 0, 1);
  endtask

  task automatic send_px(input logic [PIXEL_SIZE-1:0] d, input logic l);
    int n = 0;
    px_valid = 1'b1; px_data = d; px_last = l;
    for (int b = PB - 1; b >= 0; b--) exp_bytes.push_back(d[8*b +: 8]);
    while (!px_ready && n < 5000) begin @(negedge clk); n++; end
    if (!px_ready) chk("px_ready_timeout", 0, 1);
    @(posedge clk); #1;
    px_valid = 1'b0;
    repeat ($urandom_range(0, 30)) @(negedge clk);
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [15:0] arg);
    int na = n_args(op);
    int flen = 1;
    @(negedge clk);
    wait_ready();
    cmd_valid = 1'b1; cmd_opcode = op; cmd_arg = arg;
    if (na != 3) begin px_valid = 1'($urandom_range(0, 1)); px_data = PIXEL_SIZE'($urandom); px_last = 1'b1; end
    exp_bytes.push_back(op);
    if (na == 2) begin exp_bytes.push_back(arg[15:8]); flen++; end
    if (na == 1 || na == 2) begin exp_bytes.push_back(arg[7:0]); flen++; end
    @(posedge clk); #1;
    chk("busy_after_accept", busy, 1);
    if (na != 3) begin
      cmd_opcode = ~op; cmd_arg = ~arg;
      repeat (20) @(negedge clk);
      cmd_valid = 1'b0; px_valid = 1'b0;
    end else begin
      cmd_valid = 1'b0;
      foreach (px_q[i]) begin send_px(px_q[i], i == px_q.size() - 1); flen += PB; end
    end
    exp_len.push_back(flen);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n, r;
    logic prev;
    #3 rst_n = 1'b0;
    #1;
    chk("reset_lines_ss_sclk_mosi", {hw_spi_ss, hw_spi_clk, hw_spi_mosi}, 3'b100);
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_px_ready", px_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_miso_byte", miso_byte, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send_cmd(8'h01, 16'h0002);
    send_cmd(8'h04, 16'h0123);
    send_cmd(8'h00, 16'h5A5A);
    px_q = '{16'hF800, 16'h07E0};
    send_cmd(8'h0C, 16'h0000);
    @(negedge clk); wait_ready();
    fix_miso = 1'b1;
    send_cmd(8'h02, 16'h0033);
    @(negedge clk); wait_ready();
    chk("miso_byte_a5", miso_byte, 8'hA5);
    fix_miso = 1'b0;
    @(negedge clk); wait_ready();
    cmd_valid = 1'b1; cmd_opcode = 8'h05; cmd_arg = 16'hBEEF;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = 0; r = 0; prev = 1'b0;
    while (r < 6 && n < 2000) begin
      @(negedge clk);
      if (hw_spi_clk && !prev) r++;
      prev = hw_spi_clk; n++;
    end
    chk("abort_reached_mid_byte", r, 6);
    chk("abort_lines_before_reset", {hw_spi_ss, hw_spi_clk, hw_spi_mosi}, 3'b011);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_lines_after_reset", {hw_spi_ss, hw_spi_clk, hw_spi_mosi}, 3'b100);
    chk("abort_cmd_ready", cmd_ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_miso_byte", miso_byte, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send_cmd(8'h05, 16'h1234);
    for (int t = 0; t < 25; t++) begin
      int k = $urandom_range(0, 15);
      logic [7:0] op = k <= 12 ? 8'(k) : k == 13 ? 8'hFF : 8'($urandom);
      px_q.delete();
      repeat ($urandom_range(1, 3)) px_q.push_back(PIXEL_SIZE'($urandom));
      send_cmd(op, 16'($urandom));
    end
    @(negedge clk); wait_ready();
    repeat (2) @(negedge clk);
    chk("leftover_expected_bytes", exp_bytes.size(), 0);
    chk("leftover_expected_frames", exp_len.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
